// File: rtl/di_fifo_terminal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : di_fifo_terminal_pkg
// Description : Shared constants for the FIFO terminal: register offsets,
//               control/flag bit positions and read-handshake state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package di_fifo_terminal_pkg;

    // Register offsets on di_reg_addr
    localparam logic [31:0] c_REG_DATA  = 32'd0;
    localparam logic [31:0] c_REG_COUNT = 32'd1;
    localparam logic [31:0] c_REG_CTRL  = 32'd2;
    localparam logic [31:0] c_REG_FLAGS = 32'd3;

    // Control register bit: writing 1 flushes the FIFO
    localparam int c_CTRL_FLUSH = 0;

    // Flag bit positions inside the status / flags register
    localparam int c_FLAG_OVERFLOW  = 0;
    localparam int c_FLAG_UNDERFLOW = 1;

    // Read-handshake states
    localparam logic [0:0] c_RD_IDLE  = 1'b0;
    localparam logic [0:0] c_RD_FETCH = 1'b1;

    // Sticky per-transfer flags; packed so underflow lands on bit 1
    typedef struct packed {
        logic underflow;
        logic overflow;
    } term_flags_t;

endpackage : di_fifo_terminal_pkg
`default_nettype wire

// File: rtl/di_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : di_fifo_ram
// Description : Single-clock simple dual-port RAM with registered read.
//               A write colliding with the read address is forwarded so the
//               read port always returns the newest word.
// Revision    : 1.0 - initial release
// ============================================================================
module di_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              ifclk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port plus registered read with write-through on address collision
    always_ff @(posedge ifclk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : di_fifo_ram
`default_nettype wire

// File: rtl/di_fifo_terminal.sv
`default_nettype none
// ============================================================================
// Module      : di_fifo_terminal
// Description : HostInterface terminal exposing a 16-bit FIFO with count,
//               flush control and sticky overflow/underflow flags. Reads use
//               a two-cycle req -> rdy handshake with registered data.
// Revision    : 1.0 - initial release
// ============================================================================
module di_fifo_terminal
    import di_fifo_terminal_pkg::*;
#(
    parameter logic [15:0] TERM_ADDR  = 16'h0010,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic        di_read_mode,
    input  logic        di_write_mode,
    input  logic        di_read_req,
    input  logic        di_read,
    input  logic        di_write,
    input  logic [15:0] di_reg_datai,
    output logic [15:0] di_reg_datao,
    output logic        di_read_rdy,
    output logic        di_write_rdy,
    output logic [15:0] di_transfer_status
);

    localparam int                  c_DEPTH      = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = (DEPTH_LOG2+1)'(c_DEPTH);

    logic                  w_sel, w_addr_data, w_full, w_empty;
    logic                  w_write, w_read, w_push, w_pop, w_flush;
    logic                  w_overflow, w_underflow, w_mode_rise, w_load;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_pres_valid;
    logic                  r_read_mode_q, r_write_mode_q;
    term_flags_t           r_flags, w_flags_nxt;
    logic [0:0]            r_rd_state, w_rd_state_nxt;
    logic [15:0]           r_datao, w_load_data, w_ram_rdata;

    assign w_sel       = (di_term_addr == TERM_ADDR);
    assign w_addr_data = (di_reg_addr == c_REG_DATA);
    assign w_full      = (r_count == c_FULL_COUNT);
    assign w_empty     = (r_count == '0);

    // Write strobe wins when both strobes arrive together
    assign w_write     = w_sel && di_write;
    assign w_read      = w_sel && di_read && !di_write;
    assign w_push      = w_write && w_addr_data && !w_full;
    assign w_overflow  = w_write && w_addr_data && w_full;
    assign w_flush     = w_write && (di_reg_addr == c_REG_CTRL) && di_reg_datai[c_CTRL_FLUSH];
    assign w_pop       = w_read && w_addr_data && r_pres_valid;
    assign w_underflow = w_read && w_addr_data && !r_pres_valid;
    assign w_mode_rise = w_sel && ((di_read_mode && !r_read_mode_q) ||
                                   (di_write_mode && !r_write_mode_q));

    // RAM reads the pointer the next cycle will hold, so its output always tracks the head
    assign w_rd_ptr_nxt = w_flush ? '0 : (w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr);

    di_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (16)
    ) u_ram (
        .ifclk   (ifclk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (di_reg_datai),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (w_ram_rdata)
    );

    // Read-handshake state register
    always_ff @(posedge ifclk) begin
        if (!resetb) begin
            r_rd_state <= c_RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Next state: a request starts a fetch that completes once data can be presented
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_RD_IDLE:  if (w_sel && di_read_req) w_rd_state_nxt = c_RD_FETCH;
            c_RD_FETCH: if (w_load)               w_rd_state_nxt = c_RD_IDLE;
            default:                              w_rd_state_nxt = c_RD_IDLE;
        endcase
    end

    // Handshake outputs: load waits for a stable, non-empty head on the data register
    always_comb begin
        w_load      = (r_rd_state == c_RD_FETCH) &&
                      (!w_addr_data || (!w_empty && !w_pop && !w_flush));
        di_read_rdy = !w_sel || ((r_rd_state == c_RD_IDLE) && !di_read_req);
    end

    // Select the value presented for the addressed register
    always_comb begin
        w_load_data = 16'h0000;
        case (di_reg_addr)
            c_REG_DATA:  w_load_data = w_ram_rdata;
            c_REG_COUNT: w_load_data = 16'(r_count);
            c_REG_FLAGS: w_load_data = {14'b0, r_flags};
            default:     w_load_data = 16'h0000;
        endcase
    end

    // Sticky flags restart at the start of each transfer; a same-cycle event still sticks
    always_comb begin
        w_flags_nxt           = w_mode_rise ? '0 : r_flags;
        w_flags_nxt.overflow  = w_flags_nxt.overflow  | w_overflow;
        w_flags_nxt.underflow = w_flags_nxt.underflow | w_underflow;
    end

    // FIFO pointers, occupancy, presented word and flags
    always_ff @(posedge ifclk) begin
        if (!resetb) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_pres_valid   <= 1'b0;
            r_flags        <= '0;
            r_datao        <= 16'h0000;
            r_read_mode_q  <= 1'b0;
            r_write_mode_q <= 1'b0;
        end else begin
            r_read_mode_q  <= di_read_mode;
            r_write_mode_q <= di_write_mode;
            r_flags        <= w_flags_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (w_pop) begin
                r_count  <= r_count - 1'b1;
            end
            if (w_load) begin
                r_datao <= w_load_data;
            end
            if (w_flush || w_pop) begin
                r_pres_valid <= 1'b0;
            end else if (w_load) begin
                r_pres_valid <= w_addr_data;
            end
        end
    end

    assign di_reg_datao       = r_datao;
    assign di_write_rdy       = !w_sel || !w_addr_data || !w_full;
    assign di_transfer_status = w_sel ? {14'b0, r_flags} : 16'h0000;

endmodule : di_fifo_terminal
`default_nettype wire
